// File: rtl/flush_pkg.sv
// Shared types for the flush/redirect sequencer.
package flush_pkg;

   localparam int PC_W = 32;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DRAIN   = 3'd1,
      S_ICINV   = 3'd2,
      S_TLBREQ  = 3'd3,
      S_TLBWAIT = 3'd4,
      S_REDIR   = 3'd5
   } flush_state_t;

endpackage

// File: rtl/flush_ctrl_inv_walker.sv
// I-cache set walker: steps the set index on each accepted invalidate and
// flags acceptance of the final set.
module inv_walker #(
   parameter int ICACHE_SETS = 16,
   parameter int IDX_W       = $clog2(ICACHE_SETS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             active,
   input  logic             ready,
   output logic [IDX_W-1:0] idx,
   output logic             last
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ICACHE_SETS - 1);

   logic [IDX_W-1:0] cnt;

   // The walk wraps to 0 by natural overflow; start re-zeroes it anyway so a
   // fresh walk never inherits a stale index.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (start)
         cnt <= '0;
      else if (active && ready)
         cnt <= cnt + IDX_W'(1);
   end

   assign idx  = cnt;
   assign last = active && ready && (cnt == LAST_IDX);

endmodule

// File: rtl/flush_ctrl.sv
// Flush/redirect sequencer: drain LSU, optionally invalidate I-cache and flush
// TLB, then hand the new PC to the IFU.
module flush_ctrl
   import flush_pkg::*;
#(
   parameter int ICACHE_SETS = 16,
   parameter int IDX_W       = $clog2(ICACHE_SETS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_flush,
   input  logic [31:0]      req_dnpc,
   input  logic             req_icache,
   input  logic             req_tlb,
   input  logic             lsu_idle,
   output logic             pipe_flush,
   output logic             busy,
   output logic             ic_inv_valid,
   output logic [IDX_W-1:0] ic_inv_idx,
   input  logic             ic_inv_ready,
   output logic             tlb_flush,
   input  logic             tlb_flush_done,
   output logic             redir_valid,
   output logic [31:0]      redir_pc,
   input  logic             redir_ready
);

   flush_state_t    state;
   logic [PC_W-1:0] dnpc_q;
   logic            ic_q;
   logic            tlb_q;
   logic            accept;
   logic            walk_start;
   logic            walk_last;

   // A request is taken in IDLE, or in the closing REDIR cycle so a
   // back-to-back flush needs no idle bubble.
   assign accept     = req_flush && ((state == S_IDLE) ||
                                     ((state == S_REDIR) && redir_ready));
   assign walk_start = (state == S_DRAIN) && lsu_idle && ic_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         dnpc_q <= '0;
         ic_q   <= 1'b0;
         tlb_q  <= 1'b0;
      end else begin
         if (accept) begin
            dnpc_q <= req_dnpc;
            ic_q   <= req_icache;
            tlb_q  <= req_tlb;
         end
         case (state)
            S_IDLE:
               if (accept) state <= S_DRAIN;
            S_DRAIN:
               if (lsu_idle) begin
                  if (ic_q)       state <= S_ICINV;
                  else if (tlb_q) state <= S_TLBREQ;
                  else            state <= S_REDIR;
               end
            S_ICINV:
               if (walk_last) state <= tlb_q ? S_TLBREQ : S_REDIR;
            S_TLBREQ:
               state <= S_TLBWAIT;
            // done is only looked at here, so one raised during the
            // request cycle is ignored.
            S_TLBWAIT:
               if (tlb_flush_done) state <= S_REDIR;
            S_REDIR:
               if (redir_ready) state <= accept ? S_DRAIN : S_IDLE;
            default:
               state <= S_IDLE;
         endcase
      end
   end

   inv_walker #(
      .ICACHE_SETS (ICACHE_SETS),
      .IDX_W       (IDX_W)
   ) u_walker (
      .clock  (clock),
      .reset  (reset),
      .start  (walk_start),
      .active (ic_inv_valid),
      .ready  (ic_inv_ready),
      .idx    (ic_inv_idx),
      .last   (walk_last)
   );

   assign busy         = (state != S_IDLE);
   assign ic_inv_valid = (state == S_ICINV);
   assign tlb_flush    = (state == S_TLBREQ);
   assign redir_valid  = (state == S_REDIR);
   assign redir_pc     = dnpc_q;
   assign pipe_flush   = req_flush | busy;

`ifndef SYNTHESIS
   // Writeback is held flushed while busy, so a request here is a protocol bug.
   a_no_req_while_busy : assert property (@(posedge clock) disable iff (reset)
      !(req_flush && busy && !((state == S_REDIR) && redir_ready)))
      else $error("flush_ctrl: req_flush while busy");
`endif

endmodule

// File: tb/tb_flush_ctrl.sv
// Randomized bench for flush_ctrl against a transaction-level expectation script.
module tb_flush_ctrl;

   localparam int SETS = 16;
   localparam int IW   = 4;

   logic          clock, reset;
   logic          req_flush, req_icache, req_tlb, lsu_idle;
   logic [31:0]   req_dnpc;
   logic          pipe_flush, busy, ic_inv_valid, ic_inv_ready;
   logic [IW-1:0] ic_inv_idx;
   logic          tlb_flush, tlb_flush_done;
   logic          redir_valid, redir_ready;
   logic [31:0]   redir_pc;

   flush_ctrl #(.ICACHE_SETS(SETS), .IDX_W(IW)) dut (
      .clock          (clock),
      .reset          (reset),
      .req_flush      (req_flush),
      .req_dnpc       (req_dnpc),
      .req_icache     (req_icache),
      .req_tlb        (req_tlb),
      .lsu_idle       (lsu_idle),
      .pipe_flush     (pipe_flush),
      .busy           (busy),
      .ic_inv_valid   (ic_inv_valid),
      .ic_inv_idx     (ic_inv_idx),
      .ic_inv_ready   (ic_inv_ready),
      .tlb_flush      (tlb_flush),
      .tlb_flush_done (tlb_flush_done),
      .redir_valid    (redir_valid),
      .redir_pc       (redir_pc),
      .redir_ready    (redir_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      bit          ic;
      bit          tlb;
      int          drain_d;
      int          done_d;
      int          stall_d;
      int          rdy_mode;
      bit          b2b;
   } txn_t;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   function automatic txn_t mk(logic [31:0] pc, bit ic, bit tlb, int dd, int td,
                               int sd, int rm, bit b2b);
      txn_t t;
      t.pc = pc; t.ic = ic; t.tlb = tlb; t.drain_d = dd; t.done_d = td;
      t.stall_d = sd; t.rdy_mode = rm; t.b2b = b2b;
      return t;
   endfunction

   task automatic drive_req(input txn_t t);
      req_flush  = 1'b1;
      req_dnpc   = t.pc;
      req_icache = t.ic;
      req_tlb    = t.tlb;
   endtask

   // Walks one flush sequence cycle by cycle. On entry the bench sits 1 time
   // unit after a clock edge; pre means the request was already taken.
   task automatic run(input txn_t t, input bit pre, input txn_t nxt);
      int n, guard;
      if (!pre) begin
         drive_req(t);
         lsu_idle = 1'($urandom);
         #1;
         chk("req_pipe", pipe_flush, 1);
         chk("req_busy", busy, 0);
         cyc();
      end
      req_flush  = 1'b0;
      req_dnpc   = $urandom;
      req_icache = 1'($urandom);
      req_tlb    = 1'($urandom);
      for (int k = 0; k <= t.drain_d; k++) begin
         lsu_idle       = (k == t.drain_d);
         ic_inv_ready   = 1'($urandom);
         tlb_flush_done = 1'($urandom);
         redir_ready    = 1'($urandom);
         #1;
         chk("drain_busy", busy, 1);
         chk("drain_pipe", pipe_flush, 1);
         chk("drain_inv", ic_inv_valid, 0);
         chk("drain_tlb", tlb_flush, 0);
         chk("drain_redir", redir_valid, 0);
         cyc();
      end
      if (t.ic) begin
         n = 0; guard = 0;
         while (n < SETS) begin
            case (t.rdy_mode)
               0:       ic_inv_ready = 1'b1;
               1:       ic_inv_ready = (guard % 2 == 0);
               default: ic_inv_ready = 1'($urandom);
            endcase
            lsu_idle       = 1'($urandom);
            tlb_flush_done = 1'($urandom);
            #1;
            chk("inv_valid", ic_inv_valid, 1);
            chk("inv_idx", 32'(ic_inv_idx), n);
            chk("inv_tlb", tlb_flush, 0);
            chk("inv_redir", redir_valid, 0);
            if (ic_inv_ready) n++;
            guard++;
            cyc();
            if (guard > 200) begin
               chk("inv_timeout", n, SETS);
               break;
            end
         end
      end
      if (t.tlb) begin
         tlb_flush_done = 1'($urandom);
         ic_inv_ready   = 1'($urandom);
         #1;
         chk("tlb_pulse", tlb_flush, 1);
         chk("tlb_inv", ic_inv_valid, 0);
         chk("tlb_redir", redir_valid, 0);
         cyc();
         for (int k = 0; k <= t.done_d; k++) begin
            tlb_flush_done = (k == t.done_d);
            #1;
            chk("tlbw_pulse", tlb_flush, 0);
            chk("tlbw_redir", redir_valid, 0);
            chk("tlbw_busy", busy, 1);
            cyc();
         end
      end
      for (int k = 0; k <= t.stall_d; k++) begin
         redir_ready    = (k == t.stall_d);
         ic_inv_ready   = 1'($urandom);
         tlb_flush_done = 1'($urandom);
         if (k == t.stall_d && t.b2b) drive_req(nxt);
         #1;
         chk("redir_valid", redir_valid, 1);
         chk("redir_pc", redir_pc, t.pc);
         chk("redir_tlb", tlb_flush, 0);
         chk("redir_inv", ic_inv_valid, 0);
         chk("redir_busy", busy, 1);
         cyc();
      end
      req_flush   = 1'b0;
      redir_ready = 1'($urandom);
      if (!t.b2b) begin
         #1;
         chk("idle_busy", busy, 0);
         chk("idle_redir", redir_valid, 0);
         chk("idle_pipe", pipe_flush, 0);
      end
   endtask

   task automatic run_list(input txn_t q[$]);
      txn_t nxt;
      for (int i = 0; i < q.size(); i++) begin
         nxt = (i + 1 < q.size()) ? q[i+1] : mk(0, 0, 0, 0, 0, 0, 0, 0);
         run(q[i], (i > 0) && q[i-1].b2b, nxt);
         if (!q[i].b2b) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
               lsu_idle = 1'($urandom);
               cyc();
               chk("gap_busy", busy, 0);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
      $fatal(1, "timeout");
   end

   initial begin
      txn_t dq[$];
      txn_t rq[$];
      reset = 1'b1; req_flush = 0; req_dnpc = 0; req_icache = 0; req_tlb = 0;
      lsu_idle = 0; ic_inv_ready = 0; tlb_flush_done = 0; redir_ready = 0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_pipe", pipe_flush, 0);
      chk("rst_inv", ic_inv_valid, 0);
      chk("rst_idx", 32'(ic_inv_idx), 0);
      chk("rst_tlb", tlb_flush, 0);
      chk("rst_redir", redir_valid, 0);
      chk("rst_pc", redir_pc, 0);
      cyc(); cyc();
      reset = 1'b0;

      dq.push_back(mk(32'h8000_0100, 0, 0, 0, 0, 0, 0, 0));
      dq.push_back(mk(32'h8000_0104, 0, 0, 5, 0, 0, 0, 0));
      dq.push_back(mk(32'h8000_0108, 1, 0, 0, 0, 0, 1, 0));
      dq.push_back(mk(32'h8000_010c, 1, 1, 1, 3, 0, 0, 0));
      dq.push_back(mk(32'h8000_0110, 0, 0, 0, 0, 4, 0, 1));
      dq.push_back(mk(32'h8000_0200, 0, 1, 0, 0, 0, 0, 0));
      run_list(dq);

      // Abort a walk at idx 7 with an asynchronous reset.
      drive_req(mk(32'h1234_5678, 1, 1, 0, 0, 0, 0, 0));
      lsu_idle = 1'b1;
      cyc();
      req_flush = 1'b0;
      cyc();
      ic_inv_ready = 1'b1;
      repeat (7) cyc();
      chk("abort_idx_pre", 32'(ic_inv_idx), 7);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_pipe", pipe_flush, 0);
      chk("abort_inv", ic_inv_valid, 0);
      chk("abort_idx", 32'(ic_inv_idx), 0);
      chk("abort_tlb", tlb_flush, 0);
      chk("abort_redir", redir_valid, 0);
      chk("abort_pc", redir_pc, 0);
      cyc(); cyc();
      reset = 1'b0;
      ic_inv_ready = 1'b0;
      #1;
      chk("post_abort_busy", busy, 0);
      cyc();
      run(mk(32'h8000_0300, 1, 0, 0, 0, 1, 2, 0), 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < 25; i++)
         rq.push_back(mk($urandom, 1'($urandom), 1'($urandom),
                         int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                         (i != 24) && ($urandom_range(0, 2) == 0)));
      run_list(rq);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
